// File: rtl/fsm_ring_pkg.sv
// ---------------------------------------------------------------------------
// fsm_ring_pkg : shared defaults and the ring increment helper for fsm_ring.
// ---------------------------------------------------------------------------
`default_nettype none

package fsm_ring_pkg;

  localparam int DEF_NUM_STATES = 9;
  localparam int DEF_DWELL_W    = 8;
  localparam int DEF_WRAP_W     = 16;

  // Wrapped increment around a ring of n states.
  function automatic int ring_next(input int state, input int n);
    return (state >= n - 1) ? 0 : state + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_ring_next.sv
// ---------------------------------------------------------------------------
// fsm_ring_next : combinational step logic for the ring sequencer.
// Per-state compare/AND selects the advance request of the current state,
// then load and enable gate it. A pending timeout forces a step only when no
// natural advance is requested.
// ---------------------------------------------------------------------------
`default_nettype none

module fsm_ring_next
  import fsm_ring_pkg::*;
#(
  parameter  int NUM_STATES = DEF_NUM_STATES,
  localparam int STATE_W    = $clog2(NUM_STATES)
) (
  input  logic [STATE_W-1:0]    state_i,
  input  logic [NUM_STATES-1:0] adv_i,
  input  logic                  en_i,
  input  logic                  tmo_i,
  input  logic                  load_i,
  output logic [STATE_W-1:0]    next_state_o,
  output logic                  advance_o,
  output logic                  forced_o,
  output logic                  wrap_o
);

  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);

  logic [NUM_STATES-1:0] sel;

  // One select term per state: current-state match AND its advance bit.
  for (genvar k = 0; k < NUM_STATES; k++) begin : g_sel
    assign sel[k] = (state_i == STATE_W'(k)) & adv_i[k];
  end

  // Resolve natural/forced advance, lap flag and the stepped state.
  always_comb begin
    logic go;
    logic natural;
    go           = en_i & ~load_i;
    natural      = |sel;
    advance_o    = go & (natural | tmo_i);
    forced_o     = go & ~natural & tmo_i;
    wrap_o       = advance_o & (state_i == LAST_STATE);
    next_state_o = state_i;
    if (advance_o) begin
      next_state_o = STATE_W'(ring_next(int'(state_i), NUM_STATES));
    end
  end

endmodule

`default_nettype wire

// File: rtl/fsm_ring.sv
// ---------------------------------------------------------------------------
// fsm_ring : parametrised ring sequencer with dwell timeout, jump port and
// lap counter. All outputs are registered.
// ---------------------------------------------------------------------------
`default_nettype none

module fsm_ring
  import fsm_ring_pkg::*;
#(
  parameter  int NUM_STATES = DEF_NUM_STATES,
  parameter  int DWELL_W    = DEF_DWELL_W,
  parameter  int WRAP_W     = DEF_WRAP_W,
  localparam int STATE_W    = $clog2(NUM_STATES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NUM_STATES-1:0] adv,
  input  logic                  load,
  input  logic [STATE_W-1:0]    load_state,
  input  logic [DWELL_W-1:0]    dwell_max,
  output logic [STATE_W-1:0]    state,
  output logic [DWELL_W-1:0]    dwell,
  output logic [WRAP_W-1:0]     wrap_cnt,
  output logic                  wrapped,
  output logic                  timeout,
  output logic                  bad_load
);

  // One extra bit so NUM_STATES itself is representable when it is a power of 2.
  localparam logic [STATE_W:0] NUM_STATES_C = (STATE_W + 1)'(NUM_STATES);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [WRAP_W-1:0]  wrap_cnt_q, wrap_cnt_d;
  logic               wrapped_q, wrapped_d;
  logic               timeout_q, timeout_d;
  logic               bad_load_q, bad_load_d;

  logic               tmo_cond;
  logic               load_legal;
  logic [STATE_W-1:0] step_state;
  logic               step_adv;
  logic               step_forced;
  logic               step_wrap;

  assign tmo_cond   = (dwell_max != '0) && (dwell_q == dwell_max - DWELL_W'(1));
  assign load_legal = ({1'b0, load_state} < NUM_STATES_C);

  fsm_ring_next #(
    .NUM_STATES (NUM_STATES)
  ) u_next (
    .state_i      (state_q),
    .adv_i        (adv),
    .en_i         (en),
    .tmo_i        (tmo_cond),
    .load_i       (load),
    .next_state_o (step_state),
    .advance_o    (step_adv),
    .forced_o     (step_forced),
    .wrap_o       (step_wrap)
  );

  // Next-state selection: load first, then enabled step/dwell, else hold.
  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    wrap_cnt_d = wrap_cnt_q;
    wrapped_d  = 1'b0;
    timeout_d  = 1'b0;
    bad_load_d = 1'b0;
    if (load) begin
      if (load_legal) begin
        state_d = load_state;
        dwell_d = '0;
      end else begin
        bad_load_d = 1'b1;
      end
    end else if (en) begin
      if (step_adv) begin
        state_d   = step_state;
        dwell_d   = '0;
        timeout_d = step_forced;
        wrapped_d = step_wrap;
        if (step_wrap) begin
          wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
        end
      end else if (dwell_q != '1) begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end
  end

  // State, counters and event pulses; asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= '0;
      dwell_q    <= '0;
      wrap_cnt_q <= '0;
      wrapped_q  <= 1'b0;
      timeout_q  <= 1'b0;
      bad_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      wrap_cnt_q <= wrap_cnt_d;
      wrapped_q  <= wrapped_d;
      timeout_q  <= timeout_d;
      bad_load_q <= bad_load_d;
    end
  end

  assign state    = state_q;
  assign dwell    = dwell_q;
  assign wrap_cnt = wrap_cnt_q;
  assign wrapped  = wrapped_q;
  assign timeout  = timeout_q;
  assign bad_load = bad_load_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_ring.sv
// ---------------------------------------------------------------------------
// tb_fsm_ring : directed self-checking bench for fsm_ring (default params).
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fsm_ring;

  localparam int N  = 9;
  localparam int SW = 4;
  localparam int DW = 8;
  localparam int WW = 16;

  logic          clock;
  logic          reset;
  logic          en;
  logic [N-1:0]  adv;
  logic          load;
  logic [SW-1:0] load_state;
  logic [DW-1:0] dwell_max;
  logic [SW-1:0] state;
  logic [DW-1:0] dwell;
  logic [WW-1:0] wrap_cnt;
  logic          wrapped;
  logic          timeout;
  logic          bad_load;

  int checks = 0;
  int errors = 0;

  fsm_ring #(
    .NUM_STATES (N),
    .DWELL_W    (DW),
    .WRAP_W     (WW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .adv        (adv),
    .load       (load),
    .load_state (load_state),
    .dwell_max  (dwell_max),
    .state      (state),
    .dwell      (dwell),
    .wrap_cnt   (wrap_cnt),
    .wrapped    (wrapped),
    .timeout    (timeout),
    .bad_load   (bad_load)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int s, input int d, input int w,
                         input logic wr, input logic to, input logic bl);
    chk({tag, ".state"},    32'(state),    32'(s));
    chk({tag, ".dwell"},    32'(dwell),    32'(d));
    chk({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(w));
    chk({tag, ".wrapped"},  32'(wrapped),  32'(wr));
    chk({tag, ".timeout"},  32'(timeout),  32'(to));
    chk({tag, ".bad_load"}, 32'(bad_load), 32'(bl));
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; adv = '0; load = 1'b0; load_state = '0; dwell_max = '0;
    @(negedge clock);
    tick();
    chk_all("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Full lap with every advance bit set.
    en = 1'b1; adv = '1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("lap.state",   32'(state),   32'(i % 9));
      chk("lap.wrapped", 32'(wrapped), 32'(i == 9));
      chk("lap.dwell",   32'(dwell),   32'd0);
    end
    chk("lap.wrap_cnt", 32'(wrap_cnt), 32'd1);

    // Only a non-current advance bit: state holds, dwell counts.
    adv = '0; load = 1'b1; load_state = 4'd3;
    tick();
    chk_all("load3", 3, 0, 1, 1'b0, 1'b0, 1'b0);
    load = 1'b0; adv = 9'b000010000;
    tick(); tick(); tick();
    chk_all("hold3", 3, 3, 1, 1'b0, 1'b0, 1'b0);
    adv = 9'b000001000;
    tick();
    chk_all("adv3", 4, 0, 1, 1'b0, 1'b0, 1'b0);

    // Timeout after exactly dwell_max enabled cycles.
    adv = '0; dwell_max = 8'd5; load = 1'b1; load_state = 4'd0;
    tick();
    chk_all("load0", 0, 0, 1, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    tick(); tick(); tick(); tick();
    chk_all("tmo.pre1", 0, 4, 1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("tmo.fire1", 1, 0, 1, 1'b0, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    chk_all("tmo.pre2", 1, 4, 1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("tmo.fire2", 2, 0, 1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("tmo.after", 2, 1, 1, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("tmo.dwell4", 32'(dwell), 32'd4);
    // Natural advance coinciding with the timeout condition.
    adv = 9'b000000100;
    tick();
    chk_all("tmo.natural", 3, 0, 1, 1'b0, 1'b0, 1'b0);
    adv = '0; dwell_max = '0;

    // Load beats advance, even from the last state.
    load = 1'b1; load_state = 4'd8;
    tick();
    chk_all("load8", 8, 0, 1, 1'b0, 1'b0, 1'b0);
    adv = '1; load_state = 4'd7;
    tick();
    chk_all("load7adv", 7, 0, 1, 1'b0, 1'b0, 1'b0);
    load_state = 4'd12;
    tick();
    chk_all("badload", 7, 0, 1, 1'b0, 1'b0, 1'b1);
    load = 1'b0; adv = '0;
    tick();
    chk_all("badload.clr", 7, 1, 1, 1'b0, 1'b0, 1'b0);

    // Enable dropped mid-dwell.
    tick(); tick();
    chk("en.dwell3", 32'(dwell), 32'd3);
    en = 1'b0; adv = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("en.hold.dwell", 32'(dwell), 32'd3);
      chk("en.hold.state", 32'(state), 32'd7);
    end
    en = 1'b1; adv = '0;
    tick();
    chk_all("en.resume", 7, 4, 1, 1'b0, 1'b0, 1'b0);

    // Second lap, then asynchronous reset at state 6.
    adv = '1;
    tick();
    chk_all("lap2.s8", 8, 0, 1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("lap2.s0", 0, 0, 2, 1'b1, 1'b0, 1'b0);
    adv = '0; load = 1'b1; load_state = 4'd6;
    tick();
    load = 1'b0;
    tick();
    chk_all("pre_rst", 6, 1, 2, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1; adv = '1;
    tick();
    chk_all("post_rst", 1, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
